wb_stage_ctrl: RTL and testbench
================================

Name: wb_stage_ctrl

Overview:
Control unit for the writeback pipe register. It owns the WB valid bit and generates wb_allowin, which drives the register's load enable. It gates register-file and CP0 write enables so they fire only on a real commit, and it sequences the exception/ERET flush of the earlier stages. It also keeps a retired-instruction counter for debug and performance readout.

Parameters:
FLUSH_CYCLES, 2, number of cycles spent in FLUSH after an exception or ERET commit; legal range 1..15.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
mem_to_wb_valid  input  1  MEM stage presents a valid instruction this cycle.
trace_ready  input  1  downstream debug-trace sink accepts a commit this cycle (WB ready_go).
wb_ex  input  1  ex_wb field currently held in the WB register.
wb_eret  input  1  eret_flush field currently held in the WB register.
wb_rf_we  input  1  rf_we field held in the WB register.
wb_cp0_we  input  1  cp0_we field held in the WB register.
wb_allowin  output  1  load enable for the WB pipe register; backpressure to MEM.
wb_valid  output  1  WB register holds a live instruction.
rf_we_commit  output  1  qualified register-file write enable.
cp0_we_commit  output  1  qualified CP0 write enable.
flush  output  1  one-cycle pulse that flushes IF/ID/EX/MEM.
flush_is_eret  output  1  valid with flush: 1 = redirect to EPC, 0 = redirect to exception vector.
retired_cnt  output  CNT_W  number of committed instructions.

Behaviour:
- Reset (async, rst=1): state=EMPTY, wb_valid=0, flush_cnt=0, retired_cnt=0. All combinational outputs follow from this: wb_allowin=1, all commit, flush and flush_is_eret outputs 0.
- States:
  - EMPTY: wb_valid=0.
  - VALID: wb_valid=1.
  - FLUSH: drain window; wb_valid=0.
- ready_go = trace_ready while in VALID; don't-care in other states.
- commit = wb_valid & ready_go.
- wb_allowin (combinational):
  - EMPTY: 1.
  - VALID: ready_go.
  - FLUSH: 1 (WB keeps loading garbage that is discarded, so MEM drains).
- Commit qualifiers (combinational):
  - rf_we_commit = commit & wb_rf_we & ~wb_ex.
  - cp0_we_commit = commit & wb_cp0_we & ~wb_ex.
- flush = commit & (wb_ex | wb_eret).
- flush_is_eret = flush & wb_eret & ~wb_ex. Exception has priority if both are set.
- Transitions, in priority order:
  - FLUSH:
    - Incoming mem_to_wb_valid is ignored.
    - flush_cnt decrements each cycle.
    - When flush_cnt==1: go to EMPTY if mem_to_wb_valid=0, else still EMPTY. The instruction arriving on that cycle is still a flushed-stage leftover and is dropped.
  - EMPTY or VALID with flush=1:
    - Go to FLUSH, flush_cnt<=FLUSH_CYCLES.
    - The concurrently presented MEM instruction is discarded (wb_valid<=0).
  - EMPTY or VALID with wb_allowin=1 and no flush:
    - Go to VALID if mem_to_wb_valid, else EMPTY.
  - VALID with ready_go=0:
    - Stay in VALID.
    - Hold: no commit, no flush, retired_cnt unchanged.
- retired_cnt:
  - Increments by 1 on every commit with wb_ex=0; ERET counts, an excepting instruction does not.
  - Wraps modulo 2^CNT_W with no saturation.
- Back-to-back: on consecutive valid commits with trace_ready=1, WB accepts one instruction per cycle with zero bubbles.
- rst asserted mid-FLUSH or mid-stall: immediate return to reset values, with no residual flush pulse.
- Flush latency: flush is asserted in the same cycle as the commit of the excepting/ERET instruction. MEM's instruction is dropped at that edge.

Test Plan:
- Reset then stream: rst pulse, then 4 cycles of mem_to_wb_valid=1, trace_ready=1, wb_rf_we=1 -> wb_valid=1 from cycle 1, rf_we_commit=1 for 4 consecutive cycles, retired_cnt=4, wb_allowin stays 1.
- Backpressure: VALID, trace_ready=0 for 3 cycles -> wb_allowin=0, rf_we_commit=0, retired_cnt unchanged; when trace_ready returns to 1 -> one commit, retired_cnt+1.
- Exception: WB holds wb_ex=1, wb_rf_we=1, wb_cp0_we=1, trace_ready=1 -> flush=1, flush_is_eret=0, rf_we_commit=0, cp0_we_commit=0, retired_cnt unchanged. Next 2 cycles are FLUSH with wb_valid=0 despite mem_to_wb_valid=1; state is EMPTY on the 3rd cycle.
- ERET with simultaneous ex: wb_eret=1, wb_ex=0 -> flush=1, flush_is_eret=1, retired_cnt+1. Repeat with wb_ex=1 and wb_eret=1 -> flush_is_eret=0.
- Wrap: CNT_W=4, 17 commits -> retired_cnt=1.
- Async reset mid-FLUSH: assert rst between clock edges during FLUSH -> outputs reach reset values immediately, and no flush pulse appears after release.

Source files
------------

// File: rtl/wb_stage_ctrl.sv
// Writeback-stage control: owns the WB valid bit, qualifies RF/CP0 writes, and sequences the exception/ERET flush.
// Outputs are combinational from state; wb_allowin drops only while a live WB instruction waits on trace_ready.
module wb_stage_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_to_wb_valid,
    input  logic             trace_ready,
    input  logic             wb_ex,
    input  logic             wb_eret,
    input  logic             wb_rf_we,
    input  logic             wb_cp0_we,
    output logic             wb_allowin,
    output logic             wb_valid,
    output logic             rf_we_commit,
    output logic             cp0_we_commit,
    output logic             flush,
    output logic             flush_is_eret,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_VALID = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] flush_cnt;
    logic [3:0] flush_cnt_nxt;
    logic       ready_go;
    logic       commit;

    assign wb_valid = (state == ST_VALID);
    assign ready_go = (state == ST_VALID) & trace_ready;
    assign commit   = wb_valid & ready_go;

    always_comb begin
        wb_allowin = 1'b1;
        case (state)
            ST_EMPTY: wb_allowin = 1'b1;
            ST_VALID: wb_allowin = ready_go;
            ST_FLUSH: wb_allowin = 1'b1;
            default:  wb_allowin = 1'b1;
        endcase
    end

    // An excepting instruction must not write architectural state.
    assign rf_we_commit  = commit & wb_rf_we  & ~wb_ex;
    assign cp0_we_commit = commit & wb_cp0_we & ~wb_ex;
    assign flush         = commit & (wb_ex | wb_eret);
    assign flush_is_eret = flush & wb_eret & ~wb_ex;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (state == ST_FLUSH) begin
            // Whatever MEM presents during the drain window is a flushed leftover.
            if (flush_cnt <= 4'd1) begin
                state_nxt     = ST_EMPTY;
                flush_cnt_nxt = 4'd0;
            end else begin
                flush_cnt_nxt = flush_cnt - 4'd1;
            end
        end else if (flush) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
        end else if (wb_allowin) begin
            state_nxt = mem_to_wb_valid ? ST_VALID : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            flush_cnt   <= 4'd0;
            retired_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (commit && !wb_ex)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Directed vector table for wb_stage_ctrl plus hand sequences for counter wrap and async reset during flush.
module tb_wb_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_to_wb_valid = 1'b0;
    logic        trace_ready = 1'b0;
    logic        wb_ex = 1'b0;
    logic        wb_eret = 1'b0;
    logic        wb_rf_we = 1'b0;
    logic        wb_cp0_we = 1'b0;

    logic        wb_allowin, wb_valid, rf_we_commit, cp0_we_commit, flush, flush_is_eret;
    logic [31:0] retired_cnt;
    logic        s_allowin, s_valid, s_rfc, s_cpc, s_flush, s_fie;
    logic [3:0]  s_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_to_wb_valid(mem_to_wb_valid), .trace_ready(trace_ready),
        .wb_ex(wb_ex), .wb_eret(wb_eret), .wb_rf_we(wb_rf_we), .wb_cp0_we(wb_cp0_we),
        .wb_allowin(wb_allowin), .wb_valid(wb_valid),
        .rf_we_commit(rf_we_commit), .cp0_we_commit(cp0_we_commit),
        .flush(flush), .flush_is_eret(flush_is_eret), .retired_cnt(retired_cnt)
    );

    wb_stage_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst),
        .mem_to_wb_valid(mem_to_wb_valid), .trace_ready(trace_ready),
        .wb_ex(wb_ex), .wb_eret(wb_eret), .wb_rf_we(wb_rf_we), .wb_cp0_we(wb_cp0_we),
        .wb_allowin(s_allowin), .wb_valid(s_valid),
        .rf_we_commit(s_rfc), .cp0_we_commit(s_cpc),
        .flush(s_flush), .flush_is_eret(s_fie), .retired_cnt(s_cnt)
    );

    // in  = {mem_to_wb_valid, trace_ready, wb_ex, wb_eret, wb_rf_we, wb_cp0_we}
    // exp = {wb_allowin, wb_valid, rf_we_commit, cp0_we_commit, flush, flush_is_eret}
    typedef struct {
        logic [5:0]  in;
        logic [5:0]  exp;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] in, input logic [5:0] exp, input logic [31:0] cnt);
        vec_t v;
        v.in = in; v.exp = exp; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] in);
        {mem_to_wb_valid, trace_ready, wb_ex, wb_eret, wb_rf_we, wb_cp0_we} = in;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [5:0] outs();
        return {wb_allowin, wb_valid, rf_we_commit, cp0_we_commit, flush, flush_is_eret};
    endfunction

    initial begin
        //   in          exp        cnt
        add(6'b110010, 6'b100000, 0);  // 0  EMPTY, load
        add(6'b110010, 6'b111000, 0);  // 1  stream commits
        add(6'b110010, 6'b111000, 1);  // 2
        add(6'b110010, 6'b111000, 2);  // 3
        add(6'b010010, 6'b111000, 3);  // 4  last commit, MEM idle
        add(6'b110010, 6'b100000, 4);  // 5  EMPTY, load
        add(6'b000010, 6'b010000, 4);  // 6  stall
        add(6'b000010, 6'b010000, 4);  // 7  stall
        add(6'b000010, 6'b010000, 4);  // 8  stall
        add(6'b110011, 6'b111100, 4);  // 9  released: rf+cp0 commit
        add(6'b111011, 6'b110010, 5);  // 10 exception: flush, no writes
        add(6'b110000, 6'b100000, 5);  // 11 FLUSH, MEM dropped
        add(6'b110000, 6'b100000, 5);  // 12 FLUSH last, MEM dropped
        add(6'b110000, 6'b100000, 5);  // 13 EMPTY, load
        add(6'b110100, 6'b110011, 5);  // 14 ERET: flush to EPC, counted
        add(6'b010000, 6'b100000, 6);  // 15 FLUSH
        add(6'b010000, 6'b100000, 6);  // 16 FLUSH
        add(6'b110000, 6'b100000, 6);  // 17 EMPTY, load
        add(6'b111110, 6'b110010, 6);  // 18 ex+eret: exception wins
        add(6'b000000, 6'b100000, 6);  // 19 FLUSH ignores trace_ready
        add(6'b000000, 6'b100000, 6);  // 20
        add(6'b000000, 6'b100000, 6);  // 21 EMPTY idle

        rst = 1'b1;
        #12;
        check("reset_outputs", 64'(outs()), 64'(6'b100000));
        check("reset_cnt", 64'(retired_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            @(negedge clk);
            check($sformatf("vec%0d_outputs", i), 64'(outs()), 64'(vecs[i].exp));
            check($sformatf("vec%0d_cnt", i), 64'(retired_cnt), 64'(vecs[i].cnt));
            @(posedge clk); #1;
        end

        // Counter wrap: 11 more commits bring the total to 17.
        for (int i = 0; i < 11; i++) begin
            drive(6'b110010);
            @(posedge clk); #1;
        end
        drive(6'b010010);
        @(posedge clk); #1;
        drive(6'b000000);
        @(negedge clk);
        check("total_cnt", 64'(retired_cnt), 64'd17);
        check("wrap_cnt_w4", 64'(s_cnt), 64'd1);

        // Async reset in the middle of a flush window.
        @(posedge clk); #1;
        drive(6'b110000);
        @(posedge clk); #1;
        drive(6'b111000);
        @(negedge clk);
        check("pre_rst_flush", 64'(flush), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_flush_outputs", 64'(outs()), 64'(6'b100000));
        check("rst_mid_flush_cnt", 64'(retired_cnt), 64'd0);
        check("rst_mid_flush_cnt_w4", 64'(s_cnt), 64'd0);
        drive(6'b010000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst%0d_outputs", i), 64'(outs()), 64'(6'b100000));
        end
        // EMPTY right after reset: a new instruction loads immediately.
        drive(6'b110010);
        @(posedge clk); #1;
        check("post_rst_load", 64'(outs()), 64'(6'b111000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
